// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_pkg
// Description : Shared constants for the seven-segment bus monitor: segment
//               width, active-low hex glyph table and stability FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

   localparam int SEG_W = 7;
   localparam int CNT_W = 8;

   // Active-low glyphs in gfedcba order, entry 15 first (F) down to entry 0.
   localparam logic [15:0][SEG_W-1:0] HEX_PAT = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   // Stability window states.
   localparam logic [1:0] ST_WAIT   = 2'd0;
   localparam logic [1:0] ST_ACCEPT = 2'd1;
   localparam logic [1:0] ST_HELD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sevenseg_decode.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_decode
// Description : Combinational active-low seven-segment glyph to hex nibble
//               decoder; flags any pattern outside the 16-glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_decode
   import sevenseg_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic             legal,
   output logic [3:0]       nibble
);

   // Table lookup; glyphs are unique so at most one entry matches.
   always_comb begin
      legal  = 1'b0;
      nibble = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (seg == HEX_PAT[i]) begin
            legal  = 1'b1;
            nibble = 4'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_capture
// Description : Monitors the multiplexed seven-segment bus, accepts each digit
//               after a stability window and commits complete four-digit
//               frames to a 16-bit holding register with an update strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_capture
   import sevenseg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic        board_clk,
   input  logic        reset,
   input  logic        a,
   input  logic        b,
   input  logic        c,
   input  logic        d,
   input  logic        e,
   input  logic        ff,
   input  logic        g,
   input  logic        dp,
   input  logic [3:0]  an,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        update,
   output logic [3:0]  digit_valid,
   output logic [3:0]  dp_seen,
   output logic        decode_err
);

   localparam logic [CNT_W-1:0] STABLE_C = 8'(STABLE_CYCLES);

   logic [11:0]      w_raw;
   logic [11:0]      r_sample;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;

   logic [3:0]       w_an;
   logic             w_dp;
   logic [SEG_W-1:0] w_seg;
   logic             w_blank;
   logic             w_an_ok;
   logic [1:0]       w_idx;
   logic             w_seg_legal;
   logic [3:0]       w_nibble;

   logic [3:0][3:0]  r_shadow;
   logic [3:0]       r_shadow_dp;
   logic [3:0][3:0]  w_shadow_nxt;
   logic [3:0]       w_shadow_dp_nxt;
   logic [3:0]       w_dv_nxt;
   logic             w_accept;
   logic             w_err;
   logic             w_store;
   logic             w_commit;

   assign w_raw = {an, dp, g, ff, e, d, c, b, a};
   assign w_an  = r_sample[11:8];
   assign w_dp  = r_sample[7];
   assign w_seg = r_sample[6:0];

   sevenseg_decode u_decode (
      .seg    (w_seg),
      .legal  (w_seg_legal),
      .nibble (w_nibble)
   );

   // Counter and window state: the count reflects how many consecutive edges
   // have captured the same sample; a fresh sample reloads it to 1. From the
   // post-reset value of 0 both paths give 1, so no separate start flag.
   always_comb begin
      w_count_nxt = r_count;
      w_state_nxt = r_state;
      if (w_raw != r_sample) begin
         w_count_nxt = 8'd1;
         w_state_nxt = ST_WAIT;
      end else begin
         if (r_count < STABLE_C) begin
            w_count_nxt = r_count + 8'd1;
         end
         if (w_count_nxt == STABLE_C) begin
            w_state_nxt = (r_state == ST_WAIT) ? ST_ACCEPT : ST_HELD;
         end else begin
            w_state_nxt = ST_WAIT;
         end
      end
   end

   // Input sampler, stability counter and window state registers.
   always_ff @(posedge board_clk or negedge reset) begin
      if (!reset) begin
         r_sample <= '1;
         r_count  <= '0;
         r_state  <= ST_WAIT;
      end else begin
         r_sample <= w_raw;
         r_count  <= w_count_nxt;
         r_state  <= w_state_nxt;
      end
   end

   // Anode decode: a single low bit selects a digit, all-high is blanking.
   always_comb begin
      w_blank = 1'b0;
      w_an_ok = 1'b0;
      w_idx   = 2'd0;
      case (w_an)
         4'b1110: begin w_an_ok = 1'b1; w_idx = 2'd0; end
         4'b1101: begin w_an_ok = 1'b1; w_idx = 2'd1; end
         4'b1011: begin w_an_ok = 1'b1; w_idx = 2'd2; end
         4'b0111: begin w_an_ok = 1'b1; w_idx = 2'd3; end
         4'b1111: w_blank = 1'b1;
         default: w_an_ok = 1'b0;
      endcase
   end

   // Next shadow contents if the current sample were stored.
   always_comb begin
      w_shadow_nxt           = r_shadow;
      w_shadow_nxt[w_idx]    = w_nibble;
      w_shadow_dp_nxt        = r_shadow_dp;
      w_shadow_dp_nxt[w_idx] = ~w_dp;
      w_dv_nxt               = digit_valid | (4'b0001 << w_idx);
   end

   assign w_accept = (r_state == ST_ACCEPT);
   assign w_err    = w_accept && !w_blank && !(w_an_ok && w_seg_legal);
   assign w_store  = w_accept && w_an_ok && w_seg_legal;
   assign w_commit = w_store && (w_dv_nxt == 4'b1111);

   // Shadow capture and frame commit; the fourth digit goes straight into
   // value on the same edge that clears the per-frame flags.
   always_ff @(posedge board_clk or negedge reset) begin
      if (!reset) begin
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         digit_valid <= '0;
         value       <= '0;
         dp_seen     <= '0;
         value_valid <= 1'b0;
         update      <= 1'b0;
         decode_err  <= 1'b0;
      end else begin
         update     <= w_commit;
         decode_err <= w_err;
         if (w_store) begin
            r_shadow    <= w_shadow_nxt;
            r_shadow_dp <= w_shadow_dp_nxt;
            digit_valid <= w_commit ? 4'b0000 : w_dv_nxt;
         end
         if (w_commit) begin
            value       <= w_shadow_nxt;
            dp_seen     <= w_shadow_dp_nxt;
            value_valid <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_capture
// Description : Directed self-checking bench for sevenseg_capture with
//               STABLE_CYCLES = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_capture;

   // Active-low gfedcba glyphs, written out by hand.
   localparam logic [6:0] G0 = 7'b1000000;
   localparam logic [6:0] G1 = 7'b1111001;
   localparam logic [6:0] G2 = 7'b0100100;
   localparam logic [6:0] G3 = 7'b0110000;
   localparam logic [6:0] G4 = 7'b0011001;
   localparam logic [6:0] G5 = 7'b0010010;
   localparam logic [6:0] G6 = 7'b0000010;
   localparam logic [6:0] G7 = 7'b1111000;
   localparam logic [6:0] G8 = 7'b0000000;
   localparam logic [6:0] G9 = 7'b0010000;
   localparam logic [6:0] GA = 7'b0001000;
   localparam logic [6:0] GOFF = 7'b1111111;

   logic        board_clk = 1'b0;
   logic        reset     = 1'b0;
   logic [6:0]  seg       = GOFF;
   logic        dp        = 1'b1;
   logic [3:0]  an        = 4'b1111;
   logic [15:0] value;
   logic        value_valid;
   logic        update;
   logic [3:0]  digit_valid;
   logic [3:0]  dp_seen;
   logic        decode_err;

   int checks   = 0;
   int errors   = 0;
   int upd_cnt  = 0;
   int err_cnt  = 0;
   int both_cnt = 0;

   sevenseg_capture #(.STABLE_CYCLES(4)) dut (
      .board_clk   (board_clk),
      .reset       (reset),
      .a           (seg[0]),
      .b           (seg[1]),
      .c           (seg[2]),
      .d           (seg[3]),
      .e           (seg[4]),
      .ff          (seg[5]),
      .g           (seg[6]),
      .dp          (dp),
      .an          (an),
      .value       (value),
      .value_valid (value_valid),
      .update      (update),
      .digit_valid (digit_valid),
      .dp_seen     (dp_seen),
      .decode_err  (decode_err)
   );

   always #5 board_clk = ~board_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1);
   end

   // Drive one bus pattern at a falling edge and hold it for n cycles,
   // counting output pulses seen at each following falling edge.
   task automatic hold(input logic [3:0] an_v, input logic dp_v,
                       input logic [6:0] seg_v, input int n);
      an  = an_v;
      dp  = dp_v;
      seg = seg_v;
      for (int k = 0; k < n; k++) begin
         @(negedge board_clk);
         if (update) upd_cnt++;
         if (decode_err) err_cnt++;
         if (update && decode_err) both_cnt++;
      end
   endtask

   task automatic clear_counts();
      upd_cnt  = 0;
      err_cnt  = 0;
      both_cnt = 0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         an  = 4'($urandom);
         seg = 7'($urandom);
         dp  = 1'($urandom);
         @(negedge board_clk);
         checks++;
         if (update !== 1'b0 || decode_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: update=%b decode_err=%b required 0 0", update, decode_err);
         end
      end
      checks++;
      if (value !== 16'h0000) begin
         errors++;
         $display("FAIL reset_value: got %h required 0000", value);
      end
      checks++;
      if (value_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_value_valid: got %b required 0", value_valid);
      end
      checks++;
      if (digit_valid !== 4'b0000) begin
         errors++;
         $display("FAIL reset_digit_valid: got %b required 0000", digit_valid);
      end
      checks++;
      if (dp_seen !== 4'b0000) begin
         errors++;
         $display("FAIL reset_dp_seen: got %b required 0000", dp_seen);
      end
      an  = 4'b1111;
      seg = GOFF;
      dp  = 1'b1;
      @(negedge board_clk);
      reset = 1'b1;
      hold(4'b1111, 1'b1, GOFF, 8);
   endtask

   task automatic test_clean_frame();
      clear_counts();
      hold(4'b1110, 1'b1, G4, 6);
      checks++;
      if (digit_valid !== 4'b0001) begin
         errors++;
         $display("FAIL clean_first_digit: digit_valid=%b required 0001", digit_valid);
      end
      hold(4'b1101, 1'b1, G3, 6);
      hold(4'b1011, 1'b1, G2, 6);
      hold(4'b0111, 1'b1, G1, 6);
      checks++;
      if (upd_cnt != 1) begin
         errors++;
         $display("FAIL clean_update_count: got %0d required 1", upd_cnt);
      end
      checks++;
      if (value !== 16'h1234) begin
         errors++;
         $display("FAIL clean_value: got %h required 1234", value);
      end
      checks++;
      if (value_valid !== 1'b1) begin
         errors++;
         $display("FAIL clean_value_valid: got %b required 1", value_valid);
      end
      checks++;
      if (digit_valid !== 4'b0000) begin
         errors++;
         $display("FAIL clean_digit_valid_clear: got %b required 0000", digit_valid);
      end
      checks++;
      if (err_cnt != 0) begin
         errors++;
         $display("FAIL clean_no_err: decode_err pulses %0d required 0", err_cnt);
      end
   endtask

   task automatic test_glitch();
      hold(4'b1110, 1'b1, G8, 3);
      hold(4'b1111, 1'b1, GOFF, 3);
      checks++;
      if (digit_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_no_capture: digit_valid[0]=%b required 0", digit_valid[0]);
      end
      hold(4'b1110, 1'b1, G8, 4);
      checks++;
      if (digit_valid[0] !== 1'b0) begin
         errors++;
         $display("FAIL glitch_edge4: digit_valid[0]=%b required 0", digit_valid[0]);
      end
      hold(4'b1110, 1'b1, G8, 1);
      checks++;
      if (digit_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL glitch_edge5: digit_valid[0]=%b required 1", digit_valid[0]);
      end
      hold(4'b1110, 1'b1, G8, 2);
   endtask

   task automatic test_illegal();
      clear_counts();
      hold(4'b1100, 1'b1, G8, 6);
      checks++;
      if (err_cnt != 1) begin
         errors++;
         $display("FAIL illegal_anode_err: pulses %0d required 1", err_cnt);
      end
      checks++;
      if (digit_valid !== 4'b0001) begin
         errors++;
         $display("FAIL illegal_anode_dv: got %b required 0001", digit_valid);
      end
      clear_counts();
      hold(4'b1110, 1'b1, GOFF, 6);
      checks++;
      if (err_cnt != 1) begin
         errors++;
         $display("FAIL illegal_blank_seg_err: pulses %0d required 1", err_cnt);
      end
      checks++;
      if (digit_valid !== 4'b0001 || upd_cnt != 0) begin
         errors++;
         $display("FAIL illegal_blank_seg_dv: dv=%b updates=%0d required 0001 0", digit_valid, upd_cnt);
      end
   endtask

   task automatic test_long_hold_dp();
      clear_counts();
      hold(4'b1101, 1'b1, G5, 6);
      hold(4'b1011, 1'b1, G0, 6);
      hold(4'b0111, 1'b0, GA, 300);
      checks++;
      if (upd_cnt != 1) begin
         errors++;
         $display("FAIL long_update_count: got %0d required 1", upd_cnt);
      end
      checks++;
      if (value !== 16'hA058) begin
         errors++;
         $display("FAIL long_value: got %h required a058", value);
      end
      checks++;
      if (dp_seen !== 4'b1000) begin
         errors++;
         $display("FAIL long_dp_seen: got %b required 1000", dp_seen);
      end
      checks++;
      if (digit_valid !== 4'b0000) begin
         errors++;
         $display("FAIL long_no_refire: digit_valid=%b required 0000", digit_valid);
      end
      checks++;
      if (err_cnt != 0 || both_cnt != 0) begin
         errors++;
         $display("FAIL long_pulses: err=%0d both=%0d required 0 0", err_cnt, both_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      hold(4'b1110, 1'b1, G9, 6);
      hold(4'b1101, 1'b1, G3, 6);
      checks++;
      if (digit_valid !== 4'b0011) begin
         errors++;
         $display("FAIL midreset_pre_dv: got %b required 0011", digit_valid);
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (digit_valid !== 4'b0000 || value !== 16'h0000 || value_valid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async_clear: dv=%b value=%h vv=%b required 0000 0000 0",
                  digit_valid, value, value_valid);
      end
      @(negedge board_clk);
      an  = 4'b1111;
      seg = GOFF;
      dp  = 1'b1;
      @(negedge board_clk);
      reset = 1'b1;
      hold(4'b1111, 1'b1, GOFF, 4);
      clear_counts();
      hold(4'b1110, 1'b1, G5, 6);
      hold(4'b1101, 1'b1, G6, 6);
      hold(4'b1011, 1'b1, G7, 6);
      hold(4'b0111, 1'b1, G8, 6);
      checks++;
      if (upd_cnt != 1) begin
         errors++;
         $display("FAIL midreset_update_count: got %0d required 1", upd_cnt);
      end
      checks++;
      if (value !== 16'h8765 || value_valid !== 1'b1) begin
         errors++;
         $display("FAIL midreset_value: got %h vv=%b required 8765 1", value, value_valid);
      end
   endtask

   initial begin
      test_reset();
      test_clean_frame();
      test_glitch();
      test_illegal();
      test_long_hold_dp();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
